// File: rtl/lc3_wb_pkg.sv
// rtl/lc3_wb_pkg.sv - shared select codes, FSM encoding and constants for the LC3 writeback stage
package lc3_wb_pkg;

    localparam logic [2:0] WB_SEL_ALU = 3'h0;
    localparam logic [2:0] WB_SEL_MEM = 3'h1;
    localparam logic [2:0] WB_SEL_PC  = 3'h2;

    localparam logic [2:0] NZP_RST = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    function automatic logic wb_sel_legal(input logic [2:0] sel);
        return (sel == WB_SEL_ALU) || (sel == WB_SEL_MEM) || (sel == WB_SEL_PC);
    endfunction

endpackage

// File: rtl/lc3_writeback_unit_if.sv
// rtl/lc3_writeback_unit_if.sv - retire handshake, operand read ports and status bundle of the writeback stage
interface lc3_writeback_unit_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [2:0]                 W_Control;
    logic [ADDR_W-1:0]          dr;
    logic                       reg_we;
    logic                       cc_we;
    logic [DATA_W-1:0]          aluout;
    logic [DATA_W-1:0]          pcout;
    logic [DATA_W-1:0]          memout;
    logic                       mem_valid;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [2:0]                 nzp;
    logic                       commit_valid;
    logic [CNT_W-1:0]           retire_cnt;
    logic                       err_bad_sel;

    modport slave (
        input  in_valid, W_Control, dr, reg_we, cc_we, aluout, pcout, memout, mem_valid, rd_addr,
        output in_ready, rd_data, nzp, commit_valid, retire_cnt, err_bad_sel
    );

    modport master (
        output in_valid, W_Control, dr, reg_we, cc_we, aluout, pcout, memout, mem_valid, rd_addr,
        input  in_ready, rd_data, nzp, commit_valid, retire_cnt, err_bad_sel
    );
endinterface

// File: rtl/lc3_regfile_mp.sv
// rtl/lc3_regfile_mp.sv - register file with one synchronous write port and NUM_RD combinational read ports
module lc3_regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Clear every register on reset, otherwise perform the single write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Independent combinational read ports; any port may alias any other
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            o_rdata[k*DATA_W +: DATA_W] = r_regs[i_raddr[k*ADDR_W +: ADDR_W]];
        end
    end
endmodule

// File: rtl/lc3_writeback_unit.sv
// rtl/lc3_writeback_unit.sv - LC3 writeback stage: result select, RF write, NZP update, memory stall; WB_BYPASS_EN enables write-through read forwarding
module lc3_writeback_unit
    import lc3_wb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lc3_writeback_unit_if.slave  wb
);
    wb_state_t           r_state;
    wb_state_t           w_state_nxt;
    logic [2:0]          r_sel;
    logic [ADDR_W-1:0]   r_dr;
    logic                r_reg_we;
    logic                r_cc_we;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_mem;
    logic [2:0]          r_nzp;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_mem_cap;
    logic                      w_legal;
    logic                      w_commit;
    logic                      w_rf_we;
    logic [DATA_W-1:0]         w_result;
    logic [NUM_RD*DATA_W-1:0]  w_rf_rdata;
    logic [NUM_RD*DATA_W-1:0]  w_rd_data;

    assign w_in_ready = (r_state == IDLE) || (r_state == COMMIT);
    assign w_accept   = wb.in_valid && w_in_ready;
    assign w_commit   = (r_state == COMMIT);
    assign w_legal    = wb_sel_legal(r_sel);
    assign w_rf_we    = w_commit && r_reg_we && w_legal;

    // Memory data is latched either alongside the accept or on the first mem_valid while stalled
    assign w_mem_cap  = (w_accept && (wb.W_Control == WB_SEL_MEM) && wb.mem_valid) ||
                        ((r_state == WAIT_MEM) && wb.mem_valid);

    // Select the retiring result from the captured sources
    always_comb begin
        w_result = '0;
        case (r_sel)
            WB_SEL_ALU: w_result = r_alu;
            WB_SEL_MEM: w_result = r_mem;
            WB_SEL_PC:  w_result = r_pc;
            default:    w_result = '0;
        endcase
    end

    // Next-state logic: an accept in IDLE or COMMIT either stalls for memory or goes straight to COMMIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, COMMIT: begin
                if (w_accept) begin
                    if ((wb.W_Control == WB_SEL_MEM) && !wb.mem_valid) begin
                        w_state_nxt = WAIT_MEM;
                    end else begin
                        w_state_nxt = COMMIT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                if (wb.mem_valid) begin
                    w_state_nxt = COMMIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the retiring instruction's fields on accept and memory data when it arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel    <= WB_SEL_ALU;
            r_dr     <= '0;
            r_reg_we <= 1'b0;
            r_cc_we  <= 1'b0;
            r_alu    <= '0;
            r_pc     <= '0;
            r_mem    <= '0;
        end else begin
            if (w_accept) begin
                r_sel    <= wb.W_Control;
                r_dr     <= wb.dr;
                r_reg_we <= wb.reg_we;
                r_cc_we  <= wb.cc_we;
                r_alu    <= wb.aluout;
                r_pc     <= wb.pcout;
            end
            if (w_mem_cap) begin
                r_mem <= wb.memout;
            end
        end
    end

    // Condition codes, retire counter and sticky illegal-select flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nzp <= NZP_RST;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_commit && r_cc_we && w_legal) begin
                r_nzp <= {w_result[DATA_W-1],
                          (w_result == '0),
                          !w_result[DATA_W-1] && (w_result != '0)};
            end
            if (w_commit) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept && !wb_sel_legal(wb.W_Control)) begin
                r_err <= 1'b1;
            end
        end
    end

    lc3_regfile_mp #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_rf_we),
        .i_waddr (r_dr),
        .i_wdata (w_result),
        .i_raddr (wb.rd_addr),
        .o_rdata (w_rf_rdata)
    );

    // Read ports: optionally forward the committing value to ports addressing the destination
    always_comb begin
        w_rd_data = w_rf_rdata;
`ifdef WB_BYPASS_EN
        for (int k = 0; k < NUM_RD; k++) begin
            if (w_rf_we && (wb.rd_addr[k*ADDR_W +: ADDR_W] == r_dr)) begin
                w_rd_data[k*DATA_W +: DATA_W] = w_result;
            end
        end
`endif
    end

    assign wb.in_ready     = w_in_ready;
    assign wb.rd_data      = w_rd_data;
    assign wb.nzp          = r_nzp;
    assign wb.commit_valid = w_commit;
    assign wb.retire_cnt   = r_cnt;
    assign wb.err_bad_sel  = r_err;
endmodule

// File: tb/tb_lc3_writeback_unit.sv
// tb/tb_lc3_writeback_unit.sv - directed table-driven bench for lc3_writeback_unit
module tb_lc3_writeback_unit;
    localparam int DATA_W = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W = 3;
    localparam int NUM_RD = 2;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [CNT_W-1:0] exp_cnt;

    lc3_writeback_unit_if #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
    ) wb ();

    lc3_writeback_unit #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  dr;
        logic        rwe;
        logic        cwe;
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] mem;
        logic [15:0] exp_reg;
        logic [2:0]  exp_nzp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
        wb.rd_addr = {a, a};
        #1;
        chk({name, "_p0"}, {16'h0, wb.rd_data[15:0]}, {16'h0, exp});
        chk({name, "_p1"}, {16'h0, wb.rd_data[31:16]}, {16'h0, exp});
    endtask

    task automatic idle_inputs();
        wb.in_valid  = 1'b0;
        wb.mem_valid = 1'b0;
        wb.memout    = 16'hDEAD;
    endtask

    task automatic do_retire(input logic [2:0] sel, input logic [2:0] dr, input logic rwe,
                             input logic cwe, input logic [15:0] alu, input logic [15:0] pc,
                             input logic [15:0] mem);
        @(negedge clk);
        wb.in_valid  = 1'b1;
        wb.W_Control = sel;
        wb.dr        = dr;
        wb.reg_we    = rwe;
        wb.cc_we     = cwe;
        wb.aluout    = alu;
        wb.pcout     = pc;
        wb.memout    = mem;
        wb.mem_valid = 1'b1;
        chk("accept_ready", {31'h0, wb.in_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        exp_cnt = exp_cnt + 1'b1;
        chk("commit_pulse", {31'h0, wb.commit_valid}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("commit_clear", {31'h0, wb.commit_valid}, 32'h0);
        chk("retire_cnt", {28'h0, wb.retire_cnt}, {28'h0, exp_cnt});
    endtask

    initial begin
        int commits;
        int idx;
        logic prev_acc;

        total = 0;
        bad = 0;
        exp_cnt = '0;
        rst = 1'b1;
        wb.in_valid = 1'b0; wb.W_Control = 3'd0; wb.dr = 3'd0; wb.reg_we = 1'b0; wb.cc_we = 1'b0;
        wb.aluout = 16'h0; wb.pcout = 16'h0; wb.memout = 16'h0; wb.mem_valid = 1'b0; wb.rd_addr = '0;

        //                sel  dr  rwe cwe alu      pc       mem      exp_reg  exp_nzp
        vecs[0] = '{3'd0, 3'd3, 1'b1, 1'b1, 16'h8001, 16'h1111, 16'h2222, 16'h8001, 3'b100};
        vecs[1] = '{3'd2, 3'd4, 1'b1, 1'b1, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 3'b001};
        vecs[2] = '{3'd1, 3'd5, 1'b1, 1'b1, 16'h0001, 16'h0002, 16'hABCD, 16'hABCD, 3'b100};
        vecs[3] = '{3'd0, 3'd6, 1'b0, 1'b1, 16'h0000, 16'h3333, 16'h4444, 16'h0000, 3'b010};
        vecs[4] = '{3'd0, 3'd7, 1'b1, 1'b0, 16'h0055, 16'h8888, 16'h9999, 16'h0055, 3'b010};
        vecs[5] = '{3'd0, 3'd0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 3'b100};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_nzp", {29'h0, wb.nzp}, 32'h2);
        chk("rst_cnt", {28'h0, wb.retire_cnt}, 32'h0);
        chk("rst_commit", {31'h0, wb.commit_valid}, 32'h0);
        chk("rst_err", {31'h0, wb.err_bad_sel}, 32'h0);
        chk("rst_ready", {31'h0, wb.in_ready}, 32'h1);
        rd_chk("rst_r3", 3'd3, 16'h0);

        // Table-driven retires
        for (int i = 0; i < 6; i++) begin
            do_retire(vecs[i].sel, vecs[i].dr, vecs[i].rwe, vecs[i].cwe,
                      vecs[i].alu, vecs[i].pc, vecs[i].mem);
            rd_chk($sformatf("vec%0d_reg", i), vecs[i].dr, vecs[i].exp_reg);
            chk($sformatf("vec%0d_nzp", i), {29'h0, wb.nzp}, {29'h0, vecs[i].exp_nzp});
        end

        // Memory stall: three cycles without mem_valid, then zero data
        @(negedge clk);
        wb.in_valid = 1'b1; wb.W_Control = 3'd1; wb.dr = 3'd3; wb.reg_we = 1'b1; wb.cc_we = 1'b1;
        wb.aluout = 16'h5555; wb.pcout = 16'h6666; wb.memout = 16'hFFFF; wb.mem_valid = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wb.in_valid = 1'b0;
            chk("stall_ready", {31'h0, wb.in_ready}, 32'h0);
            chk("stall_commit", {31'h0, wb.commit_valid}, 32'h0);
            rd_chk("stall_r3_hold", 3'd3, 16'h8001);
            @(posedge clk);
        end
        @(negedge clk);
        wb.memout = 16'h0000; wb.mem_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        exp_cnt = exp_cnt + 1'b1;
        chk("mem_commit", {31'h0, wb.commit_valid}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rd_chk("mem_r3", 3'd3, 16'h0000);
        chk("mem_nzp", {29'h0, wb.nzp}, 32'h2);
        chk("mem_cnt", {28'h0, wb.retire_cnt}, {28'h0, exp_cnt});

        // Back-to-back: in_valid held, next op presented after each handshake
        commits = 0;
        idx = 0;
        prev_acc = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (wb.commit_valid) commits++;
            if (prev_acc) idx++;
            if (idx < 4) begin
                wb.in_valid = 1'b1; wb.W_Control = 3'd0; wb.dr = 3'(idx + 1);
                wb.reg_we = 1'b1; wb.cc_we = 1'b1; wb.aluout = 16'(idx + 1);
                wb.pcout = 16'hF0F0; wb.mem_valid = 1'b0;
            end else begin
                wb.in_valid = 1'b0;
            end
            prev_acc = wb.in_valid && wb.in_ready;
        end
        exp_cnt = exp_cnt + 4'd4;
        chk("b2b_commits", commits, 4);
        for (int r = 1; r <= 4; r++) begin
            rd_chk($sformatf("b2b_r%0d", r), 3'(r), 16'(r));
        end
        chk("b2b_nzp", {29'h0, wb.nzp}, 32'h1);
        chk("b2b_cnt", {28'h0, wb.retire_cnt}, {28'h0, exp_cnt});

        // Illegal select retires without writing
        do_retire(3'd5, 3'd2, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        rd_chk("bad_r2", 3'd2, 16'h0002);
        chk("bad_nzp", {29'h0, wb.nzp}, 32'h1);
        chk("bad_err", {31'h0, wb.err_bad_sel}, 32'h1);
        do_retire(3'd0, 3'd6, 1'b1, 1'b0, 16'h0006, 16'h0, 16'h0);
        chk("bad_err_sticky", {31'h0, wb.err_bad_sel}, 32'h1);

        // Read during COMMIT of R5=1234 (R5 holds ABCD)
        @(negedge clk);
        wb.in_valid = 1'b1; wb.W_Control = 3'd0; wb.dr = 3'd5; wb.reg_we = 1'b1; wb.cc_we = 1'b1;
        wb.aluout = 16'h1234; wb.pcout = 16'h0; wb.mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        wb.rd_addr = {3'd6, 3'd5};
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_p0", {16'h0, wb.rd_data[15:0]}, 32'h1234);
`else
        chk("byp_p0", {16'h0, wb.rd_data[15:0]}, 32'hABCD);
`endif
        chk("byp_p1_other", {16'h0, wb.rd_data[31:16]}, 32'h0006);
        exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_chk("byp_r5_after", 3'd5, 16'h1234);

        // Reset while stalled in WAIT_MEM
        @(negedge clk);
        wb.in_valid = 1'b1; wb.W_Control = 3'd1; wb.dr = 3'd1; wb.reg_we = 1'b1; wb.cc_we = 1'b1;
        wb.mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wb.in_valid = 1'b0;
        chk("pre_rst_wait", {31'h0, wb.in_ready}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        chk("mrst_ready", {31'h0, wb.in_ready}, 32'h1);
        chk("mrst_nzp", {29'h0, wb.nzp}, 32'h2);
        chk("mrst_cnt", {28'h0, wb.retire_cnt}, 32'h0);
        chk("mrst_err", {31'h0, wb.err_bad_sel}, 32'h0);
        for (int r = 0; r < NUM_REGS; r++) begin
            rd_chk($sformatf("mrst_r%0d", r), 3'(r), 16'h0);
        end
        wb.mem_valid = 1'b1; wb.memout = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        wb.mem_valid = 1'b0;
        chk("mrst_dropped", {31'h0, wb.commit_valid}, 32'h0);
        rd_chk("mrst_r1_clean", 3'd1, 16'h0);

        // Counter wrap after 2^CNT_W retires
        for (int n = 0; n < (1 << CNT_W); n++) begin
            do_retire(3'd0, 3'd7, 1'b1, 1'b1, 16'(n), 16'h0, 16'h0);
            if (n == (1 << CNT_W) - 2) chk("cnt_max", {28'h0, wb.retire_cnt}, 32'hF);
        end
        chk("cnt_wrap", {28'h0, wb.retire_cnt}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
